// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter: FSM state encoding, size codes,
// starvation-counter width and a small owner helper.
package sram_like_arbiter_pkg;

  // FSM states; encodings are fixed so waveforms match the bridge docs.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } arb_state_e;

  // Which master currently owns the bus.
  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } arb_port_e;

  // sram-like size field: byte count encoding.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Width of the consecutive-data-grant counter.
  localparam int CNT_W = 3;

  // Owner of the bus for a given state. IDLE reports the inst port so the
  // slave-side mux parks on inst_* while nothing is granted.
  function automatic arb_port_e owner_of(arb_state_e s);
    return (s == D_ADDR || s == D_DATA) ? PORT_DATA : PORT_INST;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port. The arbiter uses the slave modport toward each CPU
// master and the master modport toward the sram-like-to-AXI bridge.
interface sram_like_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_grant_sel.sv
// Grant selector for the arbiter's IDLE state. Data wins by default.
// With ARB_STARVE_GUARD_EN defined, a counter of consecutive data grants
// taken while inst_req is waiting forces one inst grant at STARVE_LIMIT.
module arb_grant_sel
  import sram_like_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic gnt_inst_o,
  output logic gnt_data_o
);

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] cnt_q;
  logic             starve;

  // Inst has waited through STARVE_LIMIT data grants: let it through once.
  assign starve     = inst_req_i && data_req_i && (cnt_q == CNT_W'(STARVE_LIMIT));
  assign gnt_data_o = data_req_i && !starve;
  assign gnt_inst_o = inst_req_i && !gnt_data_o;

  // Count data grants taken over a pending inst request; any inst grant or
  // an idle cycle without inst_req restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (idle_i) begin
      if (!inst_req_i || gnt_inst_o) begin
        cnt_q <= '0;
      end else if (gnt_data_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_guard;

  // Strict data priority; no counter state exists in this build.
  assign gnt_data_o   = data_req_i;
  assign gnt_inst_o   = inst_req_i && !data_req_i;
  assign unused_guard = &{1'b0, clk, rst, idle_i, STARVE_LIMIT[0]};
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like bus between instruction fetch and
// load/store. One outstanding transaction; data has priority. Handshakes go
// back to the owning master only. Optional macro ARB_STARVE_GUARD_EN bounds
// how long a pending inst request can be starved by data traffic.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  inst_if,
  sram_like_arbiter_if.slave  data_if,
  sram_like_arbiter_if.master bus_if
);

  arb_state_e    state_q;
  arb_port_e     owner;
  logic          gnt_inst, gnt_data;
  logic          i_addr, i_data, d_addr, d_data;
  logic          own_req;
  logic          mux_wr;
  logic [1:0]    mux_size;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;

  assign i_addr = (state_q == I_ADDR);
  assign i_data = (state_q == I_DATA);
  assign d_addr = (state_q == D_ADDR);
  assign d_data = (state_q == D_DATA);
  assign owner  = owner_of(state_q);

  arb_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_sel (
    .clk        (clk),
    .rst        (rst),
    .idle_i     (state_q == IDLE),
    .inst_req_i (inst_if.req),
    .data_req_i (data_if.req),
    .gnt_inst_o (gnt_inst),
    .gnt_data_o (gnt_data)
  );

  // Slave-side request fields follow the owner; IDLE parks on inst_*.
  always_comb begin
    mux_wr    = inst_if.wr;
    mux_size  = inst_if.size;
    mux_addr  = inst_if.addr;
    mux_wdata = inst_if.wdata;
    own_req   = 1'b0;
    if (owner == PORT_DATA) begin
      mux_wr    = data_if.wr;
      mux_size  = data_if.size;
      mux_addr  = data_if.addr;
      mux_wdata = data_if.wdata;
    end
    // A request is only driven during the address phase, and only while the
    // owner still holds it; a dropped request leaves bus_req low.
    if (i_addr) own_req = inst_if.req;
    if (d_addr) own_req = data_if.req;
  end

  assign bus_if.req   = own_req;
  assign bus_if.wr    = mux_wr;
  assign bus_if.size  = mux_size;
  assign bus_if.addr  = mux_addr;
  assign bus_if.wdata = mux_wdata;

  // addr_ok is gated by the owner's req so a slave accept that coincides with
  // a dropped request is not reported to a master that no longer asks.
  assign inst_if.addr_ok = i_addr && inst_if.req && bus_if.addr_ok;
  assign data_if.addr_ok = d_addr && data_if.req && bus_if.addr_ok;

  // data_ok reaches the owner either in its data phase or in the same cycle
  // as the address accept; handshakes seen in IDLE are dropped.
  assign inst_if.data_ok = (i_data && bus_if.data_ok) ||
                           (inst_if.addr_ok && bus_if.data_ok);
  assign data_if.data_ok = (d_data && bus_if.data_ok) ||
                           (data_if.addr_ok && bus_if.data_ok);

  // Read data is shared; each master only looks at it with its own data_ok.
  assign inst_if.rdata = bus_if.rdata;
  assign data_if.rdata = bus_if.rdata;

  // Transaction FSM. Grants are registered, and completion always returns to
  // IDLE, which leaves one idle bus cycle between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_data)      state_q <= D_ADDR;
          else if (gnt_inst) state_q <= I_ADDR;
        end
        I_ADDR: begin
          if (!inst_if.req)        state_q <= IDLE;
          else if (bus_if.addr_ok) state_q <= bus_if.data_ok ? IDLE : I_DATA;
        end
        I_DATA: begin
          if (bus_if.data_ok) state_q <= IDLE;
        end
        D_ADDR: begin
          if (!data_if.req)        state_q <= IDLE;
          else if (bus_if.addr_ok) state_q <= bus_if.data_ok ? IDLE : D_DATA;
        end
        D_DATA: begin
          if (bus_if.data_ok) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like bus between two CPU-side masters: instruction fetch (inst_*) and load/store (data_*).
- Sits between the core's fetch/MEM stages and the sram-like-to-AXI bridge.
- Allows one outstanding transaction at a time; the data port has priority because the MEM-stage access is older.
- Routes addr_ok and data_ok back to the owning master only.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while inst_req is pending. Used only with ARB_STARVE_GUARD_EN.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  instruction request; held until inst_addr_ok.
- inst_wr  in  1  write flag; always 0 in practice but passed through.
- inst_size  in  2  byte count encoding: 0=1B, 1=2B, 2=4B.
- inst_addr  in  AW  request address.
- inst_wdata  in  DW  write data.
- inst_addr_ok  out  1  request accepted.
- inst_data_ok  out  1  read data valid or write done.
- inst_rdata  out  DW  read data.
- data_req, data_wr, data_size, data_addr, data_wdata  in  as inst_*  data-side request.
- data_addr_ok, data_data_ok  out  1  data-side handshake.
- data_rdata  out  DW  data-side read data.
- bus_req, bus_wr  out  1  slave-side request and write flag.
- bus_size  out  2  slave-side size.
- bus_addr  out  AW  slave-side address.
- bus_wdata  out  DW  slave-side write data.
- bus_addr_ok, bus_data_ok  in  1  slave handshake.
- bus_rdata  in  DW  slave read data.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. Reset state is IDLE.
- IDLE, grant decision registered:
  - data_req=1 → D_ADDR.
  - Otherwise inst_req=1 → I_ADDR.
  - Otherwise stay in IDLE.
  - Both requesting → D_ADDR.
  - Latency: a request sampled in IDLE at cycle N drives bus_req at cycle N+1.
- X_ADDR (X = I or D):
  - bus_req = X_req; bus_wr/size/addr/wdata = X_* (combinational mux).
  - X_addr_ok = bus_addr_ok; the other port's addr_ok = 0.
  - bus_addr_ok=1 with bus_data_ok=0 → X_DATA.
  - bus_addr_ok=1 with bus_data_ok=1 in the same cycle → forward data_ok and rdata to X, go to IDLE.
  - X_req dropped before addr_ok is a protocol violation: bus_req=0, return to IDLE.
- X_DATA:
  - bus_req = 0.
  - X_data_ok = bus_data_ok; X_rdata = bus_rdata.
  - bus_data_ok=1 → IDLE.
  - No new grant in the same cycle, so the bus sees one idle cycle between transactions.
- The non-owner's addr_ok and data_ok are always 0. inst_rdata and data_rdata are both bus_rdata; they are valid only with their own data_ok.
- Any bus_addr_ok/bus_data_ok arriving in IDLE is ignored; nothing is forwarded.
- Reset values: state=IDLE, bus_req=0, all *_addr_ok=0, all *_data_ok=0, starvation counter=0. bus_addr/wdata/wr/size mux from inst_* when idle.
- Reset mid-transaction aborts to IDLE with no data_ok delivered. The bridge is reset by the same rst.

Optional Feature:
- ARB_STARVE_GUARD_EN defined:
  - A 3-bit counter increments on each D grant while inst_req=1.
  - Cleared on any I grant, or in IDLE when inst_req=0.
  - When count==STARVE_LIMIT and both requests are pending in IDLE, grant I.
- Undefined: strict data priority; the counter is not synthesized.

Decomposition:
- Header arb_defines.vh holds:
  - state encodings: IDLE=3'd0, I_ADDR=3'd1, I_DATA=3'd2, D_ADDR=3'd3, D_DATA=3'd4;
  - size encodings SIZE_B, SIZE_H, SIZE_W.
- One sub-module, arb_grant_sel: takes both requests plus the starvation counter and returns the grant. It also owns the counter under ARB_STARVE_GUARD_EN.

Test Plan:
- Inst only: inst_req=1, addr=0xBFC00000, slave addr_ok at cycle 2, data_ok at cycle 4 with rdata=0x3C080001 → inst_addr_ok one cycle, inst_data_ok one cycle with rdata 0x3C080001, data_* ok stay 0.
- Simultaneous requests: inst_req and data_req (wr=1, addr=0x80001000, wdata=0xDEADBEEF) rise together in IDLE → bus first shows the data write. Inst is granted only after data_data_ok plus one IDLE cycle.
- Same-cycle addr_ok+data_ok for an inst read → inst_data_ok and rdata forwarded that cycle, state returns to IDLE, next grant on the following cycle.
- Reset asserted in D_DATA → next cycle bus_req=0, state IDLE. A late bus_data_ok produces no data_data_ok.
- ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, data_req and inst_req held continuously → grant sequence D,D,D,D,I,D... Without the macro → D only.
